regfile_debug_reader: RTL and testbench

- Drives the register file's debug read port (`read_address_debug`, `clock_debug`) and sweeps a range of registers.
- Captures each returned word and presents it as an (address, data) stream with a valid/ready handshake, for a UART dumper or display controller.
- Sits beside the register file in the processor top level and runs independently of the pipeline read ports.

---
 rtl/regfile_debug_reader_if.sv | 12 +
 rtl/regfile_debug_reader.sv | 106 ++++++++++
 tb/tb_regfile_debug_reader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/regfile_debug_reader_if.sv
// regfile_debug_reader_if: (address, data) word stream with a valid/ready handshake.
interface regfile_debug_reader_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  modport master (output out_valid, out_addr, out_data, input out_ready);
  modport slave  (input out_valid, out_addr, out_data, output out_ready);
endinterface

// File: rtl/regfile_debug_reader.sv
// regfile_debug_reader: sweeps a register range through the register file debug port
// and streams each word out as (address, data).
module regfile_debug_reader #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] read_address_debug,
  output logic                  clock_debug,
  input  logic [DATA_WIDTH-1:0] debug_data_in,
  regfile_debug_reader_if.master stream,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, OUTPUT, FINISH} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, last_q, last_d, rad_q, rad_d, oaddr_q, oaddr_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic                  cdbg_q, cdbg_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    rad_d   = rad_q;
    cdbg_d  = cdbg_q;
    valid_d = valid_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    // abort wins over everything once a sweep is running; FINISH is already on its way out
    if (abort && state_q != IDLE && state_q != FINISH) begin
      state_d = FINISH;
      valid_d = 1'b0;
      cdbg_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          ptr_d   = first_addr;
          last_d  = last_addr;
          state_d = SETUP;
        end
        SETUP: begin
          rad_d   = ptr_q;
          state_d = STROBE;
        end
        STROBE: begin
          cdbg_d  = 1'b0;
          state_d = CAPTURE;
        end
        CAPTURE: begin
          odata_d = debug_data_in;
          oaddr_d = ptr_q;
          valid_d = 1'b1;
          cdbg_d  = 1'b1;
          state_d = OUTPUT;
        end
        OUTPUT: if (stream.out_ready) begin
          valid_d = 1'b0;
          state_d = (ptr_q == last_q) ? FINISH : SETUP;
          ptr_d   = (ptr_q == last_q) ? ptr_q : (ptr_q == LAST_REG) ? '0 : ptr_q + ADDR_WIDTH'(1);
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = state_d != IDLE;
    done_d = state_d == FINISH;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      rad_q   <= '0;
      cdbg_q  <= 1'b1;
      valid_q <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      rad_q   <= rad_d;
      cdbg_q  <= cdbg_d;
      valid_q <= valid_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign read_address_debug = rad_q;
  assign clock_debug        = cdbg_q;
  assign stream.out_valid   = valid_q;
  assign stream.out_addr    = oaddr_q;
  assign stream.out_data    = odata_q;
  assign busy               = busy_q;
  assign done               = done_q;
endmodule

// File: tb/tb_regfile_debug_reader.sv
// tb_regfile_debug_reader: directed sweeps against a behavioural register file model.
module tb_regfile_debug_reader;
  logic        clock = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [4:0]  first_addr = '0, last_addr = '0, rad;
  logic        clock_debug, busy, done;
  logic [31:0] debug_data = '0;
  logic [31:0] regs [32];
  int          checks = 0, errors = 0, done_cnt = 0, xfer_cnt = 0, fall_cnt = 0;
  regfile_debug_reader_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) sif ();
  regfile_debug_reader dut (
    .clock(clock), .reset(reset), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .abort(abort), .read_address_debug(rad), .clock_debug(clock_debug), .debug_data_in(debug_data),
    .stream(sif.master), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  always @(negedge clock_debug) begin
    debug_data <= regs[rad];
    fall_cnt++;
  end
  always @(negedge clock) if (done) done_cnt++;
  always @(posedge clock) if (sif.out_valid && sif.out_ready) xfer_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    @(negedge clock);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask
  task automatic expect_word(input logic [4:0] a, input logic [31:0] d, input int wait_exp);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sif.out_valid && n < 20);
    chk("word wait", n, wait_exp);
    chk("word addr", {27'b0, sif.out_addr}, {27'b0, a});
    chk("word data", sif.out_data, d);
  endtask
  task automatic expect_done();
    @(negedge clock);
    chk("done pulse", done, 1);
    chk("valid after last", sif.out_valid, 0);
    @(negedge clock);
    chk("done low", done, 0);
    chk("busy low", busy, 0);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = i;
    sif.out_ready = 1'b1;
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst clock_debug", clock_debug, 1);
    chk("rst rad", rad, 0);
    chk("rst valid", sif.out_valid, 0);
    chk("rst addr", sif.out_addr, 0);
    chk("rst data", sif.out_data, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    reset = 1'b0;
    do_start(0, 31);
    chk("busy rises", busy, 1);
    for (int i = 0; i < 32; i++) expect_word(5'(i), i, i == 0 ? 3 : 4);
    expect_done();
    chk("full xfers", xfer_cnt, 32);
    do_start(30, 1);
    expect_word(30, 30, 3);
    start = 1'b1;
    first_addr = 10;
    last_addr  = 10;
    @(negedge clock);
    start = 1'b0;
    expect_word(31, 31, 3);
    expect_word(0, 0, 4);
    expect_word(1, 1, 4);
    @(negedge clock);
    chk("wrap done", done, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("wrap busy0", busy, 0);
    @(negedge clock);
    chk("start in done ignored", busy, 0);
    sif.out_ready = 1'b0;
    xfer_cnt = 0;
    do_start(5, 5);
    expect_word(5, 5, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold valid", sif.out_valid, 1);
      chk("hold addr", sif.out_addr, 5);
      chk("hold data", sif.out_data, 5);
    end
    sif.out_ready = 1'b1;
    expect_done();
    chk("single xfers", xfer_cnt, 1);
    regs[7] = 32'hDEADBEEF;
    fall_cnt = 0;
    do_start(6, 8);
    expect_word(6, 6, 3);
    expect_word(7, 32'hDEADBEEF, 4);
    expect_word(8, 8, 4);
    expect_done();
    chk("strobe falls", fall_cnt, 3);
    xfer_cnt = 0;
    do_start(0, 31);
    expect_word(0, 0, 3);
    @(negedge clock);
    sif.out_ready = 1'b0;
    expect_word(1, 1, 3);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort valid", sif.out_valid, 0);
    chk("abort done", done, 1);
    chk("abort clock_debug", clock_debug, 1);
    @(negedge clock);
    chk("abort idle", busy, 0);
    chk("abort xfers", xfer_cnt, 1);
    sif.out_ready = 1'b1;
    do_start(3, 3);
    expect_word(3, 3, 3);
    expect_done();
    do_start(4, 31);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid rst clock_debug", clock_debug, 1);
    chk("mid rst rad", rad, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst valid", sif.out_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("no done on reset", done_cnt, 6);
    chk("idle after reset", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
